// File: rtl/led_sweep_ctrl_if.sv
// Button and LED-side signals of the sweep controller.
//   up_btn_n, down_btn_n, mode_btn_n : raw active-low push buttons (asynchronous)
//   leds  : one-hot LED drive, leds[7] is position 0
//   step  : one-clock pulse in the first cycle a new position is shown
//   speed : speed level, 0 slowest .. 7 fastest
//   mode  : 0 bounce, 1 wrap, 2 hold
// master is the controller side, slave is the board/stimulus side.
interface led_sweep_ctrl_if;
  logic       up_btn_n;
  logic       down_btn_n;
  logic       mode_btn_n;
  logic [7:0] leds;
  logic       step;
  logic [2:0] speed;
  logic [1:0] mode;

  modport master (
    input  up_btn_n, down_btn_n, mode_btn_n,
    output leds, step, speed, mode
  );

  modport slave (
    output up_btn_n, down_btn_n, mode_btn_n,
    input  leds, step, speed, mode
  );
endinterface

// File: rtl/led_sweep_ctrl.sv
// Sweep controller for the 8-LED scanner board. Debounces three active-low buttons into
// speed-up, speed-down and mode events, derives a step tick whose period is
// MIN_PERIOD << (7 - speed), and walks a one-hot LED position in bounce, wrap or hold mode.
//   hwclk : system clock
//   reset : synchronous, active-high reset
//   bus   : led_sweep_ctrl_if.master (buttons in; leds, step, speed, mode out)
module led_sweep_ctrl #(
  // Stored as a full int so the 120000 default is not truncated; the counter is sized from it.
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter logic [31:0] MIN_PERIOD      = 32'd65536,
  parameter logic [2:0]  RESET_SPEED     = 3'd3
) (
  input logic              hwclk,
  input logic              reset,
  led_sweep_ctrl_if.master bus
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StRight, StLeft} dir_e;
  typedef enum logic [1:0] {ModeBounce = 2'd0, ModeWrap = 2'd1, ModeHold = 2'd2} mode_e;

  // Button index: 0 up, 1 down, 2 mode.
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q, stable_q, stable_prev_q, arm_q, ev_q;
  logic [CntW-1:0] db_cnt_q [3];
  logic [1:0]      fill_q;

  assign raw = {bus.mode_btn_n, bus.down_btn_n, bus.up_btn_n};

  // fill_q tells when sync2_q holds a real input sample rather than its reset value. A button
  // only arms once it has been seen released, so a button held through reset raises no event
  // until it is released and pressed again.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '1;
      stable_prev_q <= '1;
      arm_q         <= '0;
      ev_q          <= '0;
      fill_q        <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CntLast) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CntW'(1);
        end
        if (fill_q == 2'd2 && sync2_q[i]) arm_q[i] <= 1'b1;
        ev_q[i] <= arm_q[i] & stable_prev_q[i] & ~stable_q[i];
      end
    end
  end

  logic [2:0]  speed_q;
  mode_e       mode_q;
  dir_e        dir_q, dir_step;
  logic [2:0]  pos_q, pos_step;
  logic [31:0] tick_q, period;
  logic        step_q;
  logic [7:0]  leds_q;
  logic        speed_inc, speed_dec;

  assign period    = MIN_PERIOD << (3'd7 - speed_q);
  assign speed_inc = ev_q[0] & ~ev_q[1] & (speed_q != 3'd7);
  assign speed_dec = ev_q[1] & ~ev_q[0] & (speed_q != 3'd0);

  // Position and direction after a step under the current mode.
  always_comb begin
    pos_step = pos_q;
    dir_step = dir_q;
    if (mode_q == ModeWrap) begin
      pos_step = pos_q + 3'd1;
      dir_step = StRight;
    end else if (dir_q == StRight) begin
      if (pos_q == 3'd7) begin
        pos_step = 3'd6;
        dir_step = StLeft;
      end else begin
        pos_step = pos_q + 3'd1;
      end
    end else begin
      if (pos_q == 3'd0) begin
        pos_step = 3'd1;
        dir_step = StRight;
      end else begin
        pos_step = pos_q - 3'd1;
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      speed_q <= RESET_SPEED;
      mode_q  <= ModeBounce;
      dir_q   <= StRight;
      pos_q   <= 3'd0;
      tick_q  <= '0;
      step_q  <= 1'b0;
      leds_q  <= 8'h80;
    end else begin
      step_q <= 1'b0;
      if (speed_inc) speed_q <= speed_q + 3'd1;
      else if (speed_dec) speed_q <= speed_q - 3'd1;

      // The step below still uses the old mode; the new one applies from the next clock.
      if (ev_q[2]) begin
        unique case (mode_q)
          ModeBounce: mode_q <= ModeWrap;
          ModeWrap:   mode_q <= ModeHold;
          default:    mode_q <= ModeBounce;
        endcase
      end

      // A real speed change restarts the period and swallows any step due this clock.
      if (speed_inc || speed_dec) begin
        tick_q <= '0;
      end else if (mode_q != ModeHold) begin
        if (tick_q == period - 32'd1) begin
          tick_q <= '0;
          step_q <= 1'b1;
          pos_q  <= pos_step;
          dir_q  <= dir_step;
          leds_q <= 8'h80 >> pos_step;
        end else begin
          tick_q <= tick_q + 32'd1;
        end
      end
    end
  end

  assign bus.leds  = leds_q;
  assign bus.step  = step_q;
  assign bus.speed = speed_q;
  assign bus.mode  = mode_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Directed bench for led_sweep_ctrl with DEBOUNCE_CYCLES=4, MIN_PERIOD=2, RESET_SPEED=3,
// so the period at speed s is 2 << (7 - s): 32 at speed 3.
module tb_led_sweep_ctrl;
  logic hwclk;
  logic reset;
  int   n_cmp;
  int   n_err;

  led_sweep_ctrl_if bus ();

  led_sweep_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MIN_PERIOD     (32'd2),
    .RESET_SPEED    (3'd3)
  ) dut (
    .hwclk(hwclk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    hwclk = 1'b0;
    forever #5 hwclk = ~hwclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Negedges until step is seen; an expired budget counts as a failed comparison.
  task automatic wait_step(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge hwclk);
      if (bus.step === 1'b1) begin
        n = i;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL step_timeout: got no step expected one within %0d clocks", budget);
    n = -1;
  endtask

  // mask bit 0 up, 1 down, 2 mode; low for low_cyc clocks then released for 10.
  task automatic press(input logic [2:0] mask, input int low_cyc);
    if (mask[0]) bus.up_btn_n = 1'b0;
    if (mask[1]) bus.down_btn_n = 1'b0;
    if (mask[2]) bus.mode_btn_n = 1'b0;
    repeat (low_cyc) @(negedge hwclk);
    bus.up_btn_n   = 1'b1;
    bus.down_btn_n = 1'b1;
    bus.mode_btn_n = 1'b1;
    repeat (10) @(negedge hwclk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge hwclk);
    reset = 1'b0;
    repeat (3) @(negedge hwclk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    @(negedge hwclk);
    n_cmp++; if (bus.leds !== 8'h80) begin n_err++; $display("FAIL rst_leds: got %h expected 80", bus.leds); end
    n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL rst_step: got %b expected 0", bus.step); end
    n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL rst_speed: got %0d expected 3", bus.speed); end
    n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL rst_mode: got %0d expected 0", bus.mode); end
    reset = 1'b0;
    wait_step(60, n);
    n_cmp++; if (n != 32) begin n_err++; $display("FAIL first_step_gap: got %0d expected 32", n); end
    n_cmp++; if (bus.leds !== 8'h40) begin n_err++; $display("FAIL first_step_leds: got %h expected 40", bus.leds); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_leds [13];
    int n;
    exp_leds = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int i = 0; i < 13; i++) begin
      wait_step(60, n);
      n_cmp++; if (n != 32) begin n_err++; $display("FAIL sweep_gap[%0d]: got %0d expected 32", i, n); end
      n_cmp++;
      if (bus.leds !== exp_leds[i]) begin
        n_err++; $display("FAIL sweep_leds[%0d]: got %h expected %h", i, bus.leds, exp_leds[i]);
      end
    end
    n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL sweep_speed: got %0d expected 3", bus.speed); end
    n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL sweep_mode: got %0d expected 0", bus.mode); end
  endtask

  task automatic test_debounce();
    int n;
    int first;
    // Three-clock glitch right after a step: no event, no counter clear.
    bus.up_btn_n = 1'b0;
    repeat (3) @(negedge hwclk);
    bus.up_btn_n = 1'b1;
    wait_step(60, n);
    n_cmp++; if (n != 29) begin n_err++; $display("FAIL glitch_gap: got %0d expected 29", n); end
    n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL glitch_speed: got %0d expected 3", bus.speed); end
    // Ten-clock press: speed 4 at edge N+7, then a fresh 16-clock period.
    first = 0;
    bus.up_btn_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge hwclk);
      if (k == 10) bus.up_btn_n = 1'b1;
      if (k == 7) begin
        n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL press_early: got %0d expected 3", bus.speed); end
      end
      if (k == 8) begin
        n_cmp++; if (bus.speed !== 3'd4) begin n_err++; $display("FAIL press_speed: got %0d expected 4", bus.speed); end
      end
      if (bus.step === 1'b1 && first == 0) first = k;
    end
    n_cmp++; if (first != 24) begin n_err++; $display("FAIL press_first_step: got %0d expected 24", first); end
    wait_step(60, n);
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL speed4_gap: got %0d expected 16", n); end
    // Long hold gives exactly one increment.
    press(3'b001, 200);
    n_cmp++; if (bus.speed !== 3'd5) begin n_err++; $display("FAIL hold_speed: got %0d expected 5", bus.speed); end
    wait_step(60, n);
    wait_step(60, n);
    n_cmp++; if (n != 8) begin n_err++; $display("FAIL speed5_gap: got %0d expected 8", n); end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    repeat (6) press(3'b001, 10);
    n_cmp++; if (bus.speed !== 3'd7) begin n_err++; $display("FAIL sat_up_speed: got %0d expected 7", bus.speed); end
    wait_step(20, n);
    wait_step(20, n);
    n_cmp++; if (n != 2) begin n_err++; $display("FAIL speed7_gap: got %0d expected 2", n); end
    // Seventh down press reaches 0; 12 clocks of the period have passed when it returns, then
    // two saturated presses add 40 without clearing the count: 256 - 52 = 204.
    repeat (7) press(3'b010, 10);
    repeat (2) press(3'b010, 10);
    n_cmp++; if (bus.speed !== 3'd0) begin n_err++; $display("FAIL sat_down_speed: got %0d expected 0", bus.speed); end
    wait_step(300, n);
    n_cmp++; if (n != 204) begin n_err++; $display("FAIL sat_down_first: got %0d expected 204", n); end
    wait_step(300, n);
    n_cmp++; if (n != 256) begin n_err++; $display("FAIL speed0_gap: got %0d expected 256", n); end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    wait_step(60, n);
    press(3'b011, 10);
    wait_step(60, n);
    n_cmp++; if (n != 12) begin n_err++; $display("FAIL simul_gap: got %0d expected 12", n); end
    n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL simul_speed: got %0d expected 3", bus.speed); end
  endtask

  task automatic test_mode();
    int n;
    int bad;
    int first;
    do_reset();
    press(3'b100, 10);
    n_cmp++; if (bus.mode !== 2'd1) begin n_err++; $display("FAIL mode_wrap: got %0d expected 1", bus.mode); end
    for (int i = 0; i < 10 && bus.leds !== 8'h01; i++) wait_step(60, n);
    n_cmp++; if (bus.leds !== 8'h01) begin n_err++; $display("FAIL wrap_reach_01: got %h expected 01", bus.leds); end
    wait_step(60, n);
    n_cmp++; if (bus.leds !== 8'h80) begin n_err++; $display("FAIL wrap_01_to_80: got %h expected 80", bus.leds); end
    repeat (7) wait_step(60, n);
    n_cmp++; if (bus.leds !== 8'h01) begin n_err++; $display("FAIL wrap_second_01: got %h expected 01", bus.leds); end
    // Hold press lands 8 clocks into the period; count freezes at 8.
    press(3'b100, 10);
    n_cmp++; if (bus.mode !== 2'd2) begin n_err++; $display("FAIL mode_hold: got %0d expected 2", bus.mode); end
    bad = 0;
    repeat (1000) begin
      @(negedge hwclk);
      if (bus.step !== 1'b0 || bus.leds !== 8'h01) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_frozen: got %0d changes expected 0", bad); end
    // Back to bounce at edge N+7; 23 more counts to 31, step at N+31, pos 7 -> 6.
    first = 0;
    bus.mode_btn_n = 1'b0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(negedge hwclk);
      if (k == 10) bus.mode_btn_n = 1'b1;
      if (bus.step === 1'b1) first = k;
    end
    bus.mode_btn_n = 1'b1;
    n_cmp++; if (first != 32) begin n_err++; $display("FAIL resume_first: got %0d expected 32", first); end
    n_cmp++; if (bus.leds !== 8'h02) begin n_err++; $display("FAIL resume_leds: got %h expected 02", bus.leds); end
    n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL mode_bounce: got %0d expected 0", bus.mode); end
    wait_step(60, n);
    n_cmp++; if (n != 32) begin n_err++; $display("FAIL resume_gap: got %0d expected 32", n); end
    n_cmp++; if (bus.leds !== 8'h04) begin n_err++; $display("FAIL resume_dir: got %h expected 04", bus.leds); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    repeat (3) press(3'b001, 10);
    press(3'b100, 10);
    for (int i = 0; i < 20 && bus.leds !== 8'h04; i++) wait_step(20, n);
    n_cmp++; if (bus.leds !== 8'h04) begin n_err++; $display("FAIL mid_pos5: got %h expected 04", bus.leds); end
    n_cmp++; if (bus.speed !== 3'd6) begin n_err++; $display("FAIL mid_speed: got %0d expected 6", bus.speed); end
    n_cmp++; if (bus.mode !== 2'd1) begin n_err++; $display("FAIL mid_mode: got %0d expected 1", bus.mode); end
    bus.down_btn_n = 1'b0;
    repeat (3) @(negedge hwclk);
    reset = 1'b1;
    @(negedge hwclk);
    n_cmp++; if (bus.leds !== 8'h80) begin n_err++; $display("FAIL mid_rst_leds: got %h expected 80", bus.leds); end
    n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL mid_rst_speed: got %0d expected 3", bus.speed); end
    n_cmp++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL mid_rst_mode: got %0d expected 0", bus.mode); end
    n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL mid_rst_step: got %b expected 0", bus.step); end
    reset = 1'b0;
    repeat (50) @(negedge hwclk);
    n_cmp++; if (bus.speed !== 3'd3) begin n_err++; $display("FAIL held_no_event: got %0d expected 3", bus.speed); end
    bus.down_btn_n = 1'b1;
    repeat (10) @(negedge hwclk);
    press(3'b010, 10);
    n_cmp++; if (bus.speed !== 3'd2) begin n_err++; $display("FAIL repress_speed: got %0d expected 2", bus.speed); end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.up_btn_n   = 1'b1;
    bus.down_btn_n = 1'b1;
    bus.mode_btn_n = 1'b1;
    test_reset();
    test_sweep();
    test_debounce();
    test_saturation();
    test_simultaneous();
    test_mode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
